// File: rtl/ssd_pkg.sv
// ssd_pkg: shared seven-segment constants (hex segment table, dash/blank cathodes, mode encoding, BCD sizing helper)
package ssd_pkg;
  typedef enum logic {MODE_HEX = 1'b0, MODE_DEC = 1'b1} mode_e;
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [7:0] CATH_BLANK = 8'hFF;
  function automatic int bcd_digits(input int w, input int n);
    int d;
    d = w * 302 / 1000 + 1;
    return d > n ? d : n + 1;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 converter; ports clk/rst, start/value in, busy, done (final-step strobe), bcd/ovf valid with done
module bin2bcd_seq import ssd_pkg::*; #(
  parameter int VALUE_WIDTH = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [VALUE_WIDTH-1:0] value,
  output logic busy,
  output logic done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic ovf
);
  localparam int BW = 4 * bcd_digits(VALUE_WIDTH, NUM_DIGITS);
  localparam int CW = $clog2(VALUE_WIDTH);
  logic [VALUE_WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0] bcd_q, bcd_d, adj;
  logic [BW:0] step;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d;
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BW / 4; i++)
      adj[4*i +: 4] = adj[4*i +: 4] >= 4'd5 ? adj[4*i +: 4] + 4'd3 : adj[4*i +: 4];
    step = {adj, bin_q[VALUE_WIDTH-1]};
    done = busy_q && cnt_q == CW'(VALUE_WIDTH - 1);
    busy_d = busy_q ? !done : start;
    bin_d = busy_q ? bin_q << 1 : start ? value : bin_q;
    bcd_d = busy_q ? step[BW-1:0] : start ? '0 : bcd_q;
    cnt_d = busy_q ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
    end
  end
  // The result is taken from the final step so the display can update on the same edge busy falls.
  assign busy = busy_q;
  assign bcd = step[4*NUM_DIGITS-1:0];
  assign ovf = |step[BW:4*NUM_DIGITS];
endmodule

// File: rtl/ssd_score_display.sv
// ssd_score_display: scanned seven-segment display; ports Clk/reset, Load/Value/Mode/LZB capture, DpMask/BlankMask live masks, Busy/Ovf status, An/Cath active-low drive
module ssd_score_display import ssd_pkg::*; #(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_WIDTH = 14,
  parameter int SCAN_DIV_BITS = 18
) (
  input  logic Clk,
  input  logic reset,
  input  logic Load,
  input  logic [VALUE_WIDTH-1:0] Value,
  input  logic Mode,
  input  logic LZB,
  input  logic [NUM_DIGITS-1:0] DpMask,
  input  logic [NUM_DIGITS-1:0] BlankMask,
  output logic Busy,
  output logic Ovf,
  output logic [NUM_DIGITS-1:0] An,
  output logic [7:0] Cath
);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [SCAN_DIV_BITS-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] disp_q, disp_d, conv_bcd;
  mode_e mode_q, mode_d;
  logic lzb_q, lzb_d, ovf_q, ovf_d;
  logic [NUM_DIGITS-1:0] an_q, an_d, sel;
  logic [7:0] cath_q, cath_d;
  logic accept, conv_done, conv_ovf, blank;
  logic [3:0] digit;
  bin2bcd_seq #(.VALUE_WIDTH(VALUE_WIDTH), .NUM_DIGITS(NUM_DIGITS)) u_conv (
    .clk(Clk),
    .rst(reset),
    .start(accept && Mode),
    .value(Value),
    .busy(Busy),
    .done(conv_done),
    .bcd(conv_bcd),
    .ovf(conv_ovf)
  );
  always_comb begin
    accept = Load && !Busy;
    cnt_d = cnt_q + 1'b1;
    idx_d = &cnt_q ? (idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
    mode_d = accept ? mode_e'(Mode) : mode_q;
    lzb_d = accept ? LZB : lzb_q;
    disp_d = accept && !Mode ? DW'(Value) : conv_done ? conv_bcd : disp_q;
    ovf_d = accept && !Mode ? 1'b0 : conv_done ? conv_ovf : ovf_q;
    sel = NUM_DIGITS'(1) << idx_q;
    digit = 4'(disp_q >> {idx_q, 2'b00});
    // Leading-zero blanking: every digit from this one upward is zero; dashes on overflow are never blanked.
    blank = |(BlankMask & sel) ||
            (lzb_q && mode_q == MODE_DEC && !ovf_q && idx_q != '0 && (disp_q >> {idx_q, 2'b00}) == '0);
    an_d = blank ? '1 : ~sel;
    cath_d = blank ? CATH_BLANK : {ovf_q ? SEG_DASH : SEG_TABLE[digit], ~|(DpMask & sel)};
  end
  always_ff @(posedge Clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      disp_q <= '0;
      mode_q <= MODE_HEX;
      lzb_q <= 1'b0;
      ovf_q <= 1'b0;
      an_q <= '1;
      cath_q <= CATH_BLANK;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      disp_q <= disp_d;
      mode_q <= mode_d;
      lzb_q <= lzb_d;
      ovf_q <= ovf_d;
      an_q <= an_d;
      cath_q <= cath_d;
    end
  end
  assign Ovf = ovf_q;
  assign An = an_q;
  assign Cath = cath_q;
endmodule

// File: tb/tb_ssd_score_display.sv
// tb_ssd_score_display: randomized bench with a behavioural display model plus literal scan checks
module tb_ssd_score_display;
  logic Clk = 1'b0, reset = 1'b1, Load = 1'b0, Mode = 1'b0, LZB = 1'b0;
  logic [13:0] Value = '0;
  logic [3:0] DpMask = '0, BlankMask = '0;
  logic Busy, Ovf;
  logic [3:0] An;
  logic [7:0] Cath;
  int checks = 0, errors = 0;
  int m_pc, m_idx, m_mode, m_lzb, m_ovf, m_left, m_pend, m_v;
  int m_dig[4];
  bit b_blank, m_valid = 1'b0, e_cath_ok;
  logic [3:0] e_an;
  logic [7:0] e_cath;
  logic [6:0] seg[16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
                          7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                          7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  int pat[4] = '{14, 13, 11, 7};

  always #5 Clk = ~Clk;

  ssd_score_display #(.NUM_DIGITS(4), .VALUE_WIDTH(14), .SCAN_DIV_BITS(2)) dut (
    .Clk(Clk), .reset(reset), .Load(Load), .Value(Value), .Mode(Mode), .LZB(LZB),
    .DpMask(DpMask), .BlankMask(BlankMask), .Busy(Busy), .Ovf(Ovf), .An(An), .Cath(Cath)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected registered outputs after each edge, from the display rules.
  always @(posedge Clk) begin
    if (reset) begin
      m_pc = 0; m_idx = 0; m_mode = 0; m_lzb = 0; m_ovf = 0; m_left = 0;
      for (int k = 0; k < 4; k++) m_dig[k] = 0;
      e_an = 4'hF; e_cath = 8'hFF; e_cath_ok = 1'b1; m_valid = 1'b1;
    end else begin
      b_blank = BlankMask[m_idx];
      if (m_lzb != 0 && m_mode != 0 && m_ovf == 0 && m_idx > 0) begin
        m_v = 0;
        for (int k = 0; k < 4; k++) if (k >= m_idx) m_v += m_dig[k];
        if (m_v == 0) b_blank = 1'b1;
      end
      e_an = b_blank ? 4'hF : ~(4'b0001 << m_idx);
      e_cath = {m_ovf != 0 ? 7'b1111110 : seg[m_dig[m_idx]], ~DpMask[m_idx]};
      e_cath_ok = !b_blank;
      if (Load && m_left == 0) begin
        m_mode = Mode; m_lzb = LZB;
        if (!Mode) begin
          for (int k = 0; k < 4; k++) m_dig[k] = (int'(Value) >> (4 * k)) % 16;
          m_ovf = 0;
        end else begin
          m_left = 14; m_pend = Value;
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_ovf = m_pend > 9999 ? 1 : 0;
          m_v = m_pend;
          for (int k = 0; k < 4; k++) begin m_dig[k] = m_v % 10; m_v = m_v / 10; end
        end
      end
      if (m_pc == 3) m_idx = (m_idx + 1) % 4;
      m_pc = (m_pc + 1) % 4;
    end
  end

  always @(posedge Clk) begin
    #1;
    if (m_valid) begin
      chk("an", An, e_an);
      if (e_cath_ok) chk("cath", Cath, e_cath);
      chk("busy", Busy, m_left > 0 ? 1 : 0);
      chk("ovf", Ovf, m_ovf);
    end
  end

  task automatic load(input int v, input logic md, input logic lz);
    @(negedge Clk);
    Value = 14'(v); Mode = md; LZB = lz; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 40) begin @(negedge Clk); n++; end
    chk("idle_timeout", Busy, 0);
  endtask

  // Watches a few full scan rounds and checks which digits light and their segments.
  task automatic scan_check(input string name, input logic [3:0][6:0] e, input logic [3:0] mask);
    logic [6:0] seen[4];
    bit lit[4];
    for (int k = 0; k < 4; k++) begin lit[k] = 1'b0; seen[k] = '1; end
    repeat (20) begin
      @(negedge Clk);
      for (int k = 0; k < 4; k++) if (An == ~(4'b0001 << k)) begin lit[k] = 1'b1; seen[k] = Cath[7:1]; end
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_lit%0d", name, k), lit[k], mask[k]);
      if (mask[k]) chk($sformatf("%s_seg%0d", name, k), seen[k], e[k]);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge Clk);
    chk("rst_an", An, 4'hF);
    chk("rst_cath", Cath, 8'hFF);
    reset = 1'b0;
    for (int k = 0; k < 17; k++) begin
      @(posedge Clk); #1;
      chk("scan_an", An, pat[(k / 4) % 4]);
    end
    load(14'h1A3F, 1'b0, 1'b0);
    scan_check("hex", {7'b1001111, 7'b0001000, 7'b0000110, 7'b0111000}, 4'hF);
    @(negedge Clk);
    Value = 14'd1234; Mode = 1'b1; LZB = 1'b0; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    n = 0;
    while (Busy && n < 40) begin n++; @(negedge Clk); end
    chk("busy_len", n, 14);
    chk("ovf_1234", Ovf, 0);
    scan_check("d1234", {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'hF);
    load(7, 1'b1, 1'b1); wait_idle();
    scan_check("lzb7", {7'h7F, 7'h7F, 7'h7F, 7'b0001111}, 4'b0001);
    load(0, 1'b1, 1'b1); wait_idle();
    scan_check("lzb0", {7'h7F, 7'h7F, 7'h7F, 7'b0000001}, 4'b0001);
    load(12000, 1'b1, 1'b0); wait_idle();
    chk("ovf_set", Ovf, 1);
    scan_check("dash", {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}, 4'hF);
    load(42, 1'b1, 1'b0); wait_idle();
    chk("ovf_clr", Ovf, 0);
    scan_check("d42", {7'b0000001, 7'b0000001, 7'b1001100, 7'b0010010}, 4'hF);
    load(1234, 1'b1, 1'b0);
    repeat (4) @(negedge Clk);
    Value = 14'd5555; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    chk("busy_ignored_load", Busy, 1);
    reset = 1'b1;
    @(negedge Clk);
    chk("abort_busy", Busy, 0);
    chk("abort_an", An, 4'hF);
    reset = 1'b0;
    scan_check("abort", {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, 4'hF);
    DpMask = 4'b0101; BlankMask = 4'b0010;
    scan_check("masks", {7'b0000001, 7'b0000001, 7'h7F, 7'b0000001}, 4'b1101);
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      Load = $urandom_range(0, 7) == 0;
      Value = $urandom_range(0, 3) == 0 ? 14'($urandom_range(0, 120)) : 14'($urandom_range(0, 16383));
      Mode = 1'($urandom_range(0, 1));
      LZB = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) DpMask = 4'($urandom);
      if ($urandom_range(0, 31) == 0) BlankMask = $urandom_range(0, 1) == 0 ? 4'h0 : 4'($urandom);
      reset = $urandom_range(0, 499) == 0;
    end
    @(negedge Clk);
    Load = 1'b0; reset = 1'b0;
    repeat (2) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ssd_score_display.md
SSD_SCORE_DISPLAY -- requirements
Module: ssd_score_display

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, number of scanned digits (legal 1..8).
REQ-002 The block SHALL have parameter VALUE_WIDTH, default 14, width of the binary value input (legal 4..27).
REQ-003 The block SHALL have parameter SCAN_DIV_BITS, default 18, meaning each digit slot lasts 2^SCAN_DIV_BITS clocks (legal 1..24).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: Clk (input, 1, system clock) and reset (input, 1, synchronous active-high reset).
REQ-005 The block SHALL have port Load, input, 1 bit: single-cycle request to capture Value.
REQ-006 The block SHALL have port Value, input, VALUE_WIDTH bits: unsigned binary number to display.
REQ-007 The block SHALL have port Mode, input, 1 bit: 0 = hex, 1 = decimal; sampled with Load.
REQ-008 The block SHALL have port LZB, input, 1 bit: leading-zero blanking enable; sampled with Load.
REQ-009 The block SHALL have port DpMask, input, NUM_DIGITS bits: per-digit decimal point on; bit i maps to digit i; live, not latched.
REQ-010 The block SHALL have port BlankMask, input, NUM_DIGITS bits: per-digit force-off; live, not latched.
REQ-011 The block SHALL have port Busy, output, 1 bit: conversion in progress.
REQ-012 The block SHALL have port Ovf, output, 1 bit: last decimal value exceeded 10^NUM_DIGITS-1.
REQ-013 The block SHALL have port An, output, NUM_DIGITS bits: active-low anodes; An[0] is the rightmost digit.
REQ-014 The block SHALL have port Cath, output, 8 bits: active-low {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}.

Function
REQ-015 The prescaler SHALL count 0..2^SCAN_DIV_BITS-1 and wrap; on wrap, the digit index SHALL advance by 1 modulo NUM_DIGITS (3 -> 0 for default).
REQ-016 An and Cath SHALL be registered and reflect the current digit index one clock after the index changes.
REQ-017 In the active slot, An SHALL have exactly one bit low (bit = index), unless that digit is blanked, in which case An SHALL be all ones.
REQ-018 A digit SHALL be blanked if its BlankMask bit is 1, or if the latched LZB=1, the latched Mode=1, the digit is above the most significant nonzero digit, and the digit index is not 0.
REQ-019 Cath[7:1] SHALL use the standard hex segment table (0 = 0000001, 8 = 0000000, F = 0111000); Cath[0] SHALL be the inverse of DpMask[index].
REQ-020 In hex mode, Load with Busy=0 SHALL update the displayed nibbles to Value (zero-extended/truncated to 4*NUM_DIGITS bits) in the next cycle; Busy SHALL stay 0.
REQ-021 In decimal mode, Load with Busy=0 SHALL start a sequential shift-add-3 conversion; Busy SHALL go high the next cycle and stay high for exactly VALUE_WIDTH cycles.
REQ-022 The displayed digits SHALL update atomically on the cycle Busy falls, never with partial results.
REQ-023 Load while Busy=1 SHALL be ignored, with no queueing.
REQ-024 In decimal mode, if Value > 10^NUM_DIGITS-1, Ovf SHALL be set and every unblanked digit SHALL show a dash (Cath[7:1] = 1111110).
REQ-025 A subsequent in-range decimal load, or any hex load, SHALL clear Ovf.
REQ-026 If Load coincides with reset, reset SHALL win.
REQ-027 DpMask and BlankMask changes SHALL take effect at the next registered output update, without a Load.

Reset
REQ-028 While reset=1 at a Clk edge, the prescaler, digit index, display register, Mode/LZB latches, Busy and Ovf SHALL all be cleared to 0, An SHALL be all ones and Cath SHALL be 8'hFF.
REQ-029 Reset asserted mid-conversion SHALL abort the conversion; the display SHALL be 0 afterwards.
REQ-030 After reset, the first anode SHALL assert (An[0] low) one clock after reset deasserts.

Structure
REQ-031 The segment table, dash/blank cathode constants and the mode encoding SHALL live in the shared package ssd_pkg.
REQ-032 The sequential binary-to-BCD converter SHALL be a sub-module named bin2bcd_seq, with Start/Busy/Done handshake and parameters VALUE_WIDTH and NUM_DIGITS.
REQ-033 Digit scan, blanking and cathode encoding SHALL stay in ssd_score_display.

Verification (SCAN_DIV_BITS=2, defaults otherwise)
REQ-034 Release reset -> An cycles 1110, 1101, 1011, 0111, 1110, with 4 clocks per slot.
REQ-035 Hex load of Value=14'h1A3F -> digits 3..0 show 1, A, 3, F; Busy is never high.
REQ-036 Decimal load of Value=1234 -> Busy high for exactly 14 cycles, then digits show 1, 2, 3, 4 and Ovf=0.
REQ-037 Decimal load of Value=7 with LZB=1 -> An[3:1] never low and digit 0 shows 7; Value=0 -> only digit 0 lit, showing 0.
REQ-038 Decimal load of Value=12000 -> Ovf=1 and all digits show a dash; then a decimal load of 42 -> Ovf=0 and digits show 0042.
REQ-039 Load issued 5 cycles into a conversion -> ignored; reset issued at cycle 7 -> Busy=0, display 0000, An=1111 during reset.
